stdp_array: RTL and testbench

STDP_ARRAY -- requirements
Module: stdp_array

---
 rtl/stdp_pkg.sv | 17 +
 rtl/stdp_array_if.sv | 25 ++
 rtl/stdp_syn.sv | 60 ++++++
 rtl/stdp_array.sv | 56 +++++
 tb/tb_stdp_array.sv | 131 +++++++++++++
 5 files changed

// File: rtl/stdp_pkg.sv
// stdp_pkg: timing-decay delta and saturating weight arithmetic helpers.
package stdp_pkg;
  function automatic int stdp_delta(int base, int dt, int sh, int w);
    int s;
    s = dt >> sh;
    return (s >= w) ? 0 : base >> s;
  endfunction
  function automatic int sat_add(int a, int d, int mx);
    return (a + d > mx) ? mx : a + d;
  endfunction
  function automatic int sat_sub(int a, int d, int mn);
    return (a - d < mn) ? mn : a - d;
  endfunction
  function automatic int clamp(int v, int mn, int mx);
    return (v < mn) ? mn : (v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/stdp_array_if.sv
// stdp_array_if: spike inputs, weight load port and learning outputs of stdp_array.
interface stdp_array_if #(
  parameter int N_SYN   = 4,
  parameter int W_WIDTH = 8
);
  localparam int IW = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  logic [N_SYN-1:0]         pre_spike;
  logic                     post_spike;
  logic                     learn_en;
  logic                     wr_en;
  logic [IW-1:0]            wr_idx;
  logic [W_WIDTH-1:0]       wr_data;
  logic [N_SYN*W_WIDTH-1:0] weight;
  logic                     upd_valid;
  logic [N_SYN-1:0]         ltp_mask;
  logic [N_SYN-1:0]         ltd_mask;
  modport master (
    output pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data,
    input  weight, upd_valid, ltp_mask, ltd_mask
  );
  modport slave (
    input  pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data,
    output weight, upd_valid, ltp_mask, ltd_mask
  );
endinterface

// File: rtl/stdp_syn.sv
// stdp_syn: one synapse -- pre timer, weight register and LTP/LTD update.
// Depression is built only when STDP_LTD_EN is defined.
module stdp_syn
  import stdp_pkg::*;
#(
  parameter int W_WIDTH  = 8,
  parameter int WINDOW   = 31,
  parameter int DECAY_SH = 2,
  parameter int A_PLUS   = 16,
  parameter int A_MINUS  = 12,
  parameter int W_INIT   = 64,
  parameter int W_MIN    = 0,
  parameter int W_MAX    = 255,
  localparam int TW      = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               learn_en,
  input  logic [TW-1:0]      post_t,
  input  logic               wr_hit,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic [W_WIDTH-1:0] weight,
  output logic               ltp,
  output logic               ltd
);
  logic [TW-1:0] pre_t;
  int ltp_d;
`ifdef STDP_LTD_EN
  int ltd_d;
`else
  logic unused_post;
  assign unused_post = ^post_t;
`endif
  always_comb begin
    ltp_d = stdp_delta(A_PLUS, int'(pre_t) + 1, DECAY_SH, W_WIDTH);
    ltp = learn_en && !wr_hit && post_spike && !pre_spike && int'(pre_t) < WINDOW && ltp_d != 0;
`ifdef STDP_LTD_EN
    ltd_d = stdp_delta(A_MINUS, int'(post_t) + 1, DECAY_SH, W_WIDTH);
    ltd = learn_en && !wr_hit && pre_spike && !post_spike && int'(post_t) < WINDOW && ltd_d != 0;
`else
    ltd = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_t  <= TW'(WINDOW);
      weight <= W_WIDTH'(W_INIT);
    end else begin
      pre_t  <= pre_spike ? '0 : (int'(pre_t) == WINDOW) ? pre_t : pre_t + TW'(1);
      weight <= wr_hit ? W_WIDTH'(clamp(int'(wr_data), W_MIN, W_MAX))
              : ltp    ? W_WIDTH'(sat_add(int'(weight), ltp_d, W_MAX))
`ifdef STDP_LTD_EN
              : ltd    ? W_WIDTH'(sat_sub(int'(weight), ltd_d, W_MIN))
`endif
              : weight;
    end
  end
endmodule

// File: rtl/stdp_array.sv
// stdp_array: N_SYN-input spike-timing-dependent plasticity weight array.
// Depression (LTD) is compiled in only when STDP_LTD_EN is defined.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int N_SYN    = 4,
  parameter int W_WIDTH  = 8,
  parameter int WINDOW   = 31,
  parameter int DECAY_SH = 2,
  parameter int A_PLUS   = 16,
  parameter int A_MINUS  = 12,
  parameter int W_INIT   = 64,
  parameter int W_MIN    = 0,
  parameter int W_MAX    = 255
) (
  input logic         clk,
  input logic         rst_n,
  stdp_array_if.slave bus
);
  localparam int TW = $clog2(WINDOW + 1);
  logic [TW-1:0]    post_t;
  logic [N_SYN-1:0] ltp;
  logic [N_SYN-1:0] ltd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_t        <= TW'(WINDOW);
      bus.upd_valid <= 1'b0;
      bus.ltp_mask  <= '0;
      bus.ltd_mask  <= '0;
    end else begin
      post_t        <= bus.post_spike ? '0 : (int'(post_t) == WINDOW) ? post_t : post_t + TW'(1);
      bus.upd_valid <= |{ltp, ltd};
      bus.ltp_mask  <= ltp;
      bus.ltd_mask  <= ltd;
    end
  end
  // Out-of-range wr_idx matches no synapse, so such writes are dropped.
  for (genvar i = 0; i < N_SYN; i++) begin : g_syn
    stdp_syn #(
      .W_WIDTH(W_WIDTH), .WINDOW(WINDOW), .DECAY_SH(DECAY_SH), .A_PLUS(A_PLUS),
      .A_MINUS(A_MINUS), .W_INIT(W_INIT), .W_MIN(W_MIN), .W_MAX(W_MAX)
    ) u_syn (
      .clk       (clk),
      .rst_n     (rst_n),
      .pre_spike (bus.pre_spike[i]),
      .post_spike(bus.post_spike),
      .learn_en  (bus.learn_en),
      .post_t    (post_t),
      .wr_hit    (bus.wr_en && 32'(bus.wr_idx) == i),
      .wr_data   (bus.wr_data),
      .weight    (bus.weight[i*W_WIDTH +: W_WIDTH]),
      .ltp       (ltp[i]),
      .ltd       (ltd[i])
    );
  end
endmodule

// File: tb/tb_stdp_array.sv
// tb_stdp_array: directed STDP timing vectors with hand-computed weights.
module tb_stdp_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  stdp_array_if #(.N_SYN(4), .W_WIDTH(8)) bus ();
  stdp_array dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
`ifdef STDP_LTD_EN
  localparam bit LTD = 1'b1;
`else
  localparam bit LTD = 1'b0;
`endif
  function automatic logic [7:0] wt(int i);
    return bus.weight[i*8 +: 8];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] pre, input logic post);
    bus.pre_spike  = pre;
    bus.post_spike = post;
    @(posedge clk);
    @(negedge clk);
    bus.pre_spike  = '0;
    bus.post_spike = 1'b0;
    bus.wr_en      = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(4'b0, 1'b0);
  endtask
  task automatic load(input logic [1:0] idx, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_data = d;
    step(4'b0, 1'b0);
  endtask
  initial begin
    bus.pre_spike = '0; bus.post_spike = 1'b0; bus.learn_en = 1'b1;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_weight", bus.weight, 32'h40404040);
    chk("rst_upd", bus.upd_valid, 0);
    chk("rst_ltp", bus.ltp_mask, 0);
    chk("rst_ltd", bus.ltd_mask, 0);
    rst_n = 1'b1;
    // pre0 e0, post e3: dt=3 -> +16
    step(4'b0001, 1'b0); idle(2); step(4'b0, 1'b1);
    chk("ltp3_w0", wt(0), 80);
    chk("ltp3_upd", bus.upd_valid, 1);
    chk("ltp3_mask", bus.ltp_mask, 4'b0001);
    chk("ltp3_ltd", bus.ltd_mask, 0);
    step(4'b0, 1'b0);
    chk("ltp3_upd_drop", bus.upd_valid, 0);
    chk("ltp3_mask_drop", bus.ltp_mask, 0);
    idle(32);
    load(2'd0, 8'd64);
    chk("load_w0", wt(0), 64);
    chk("load_no_upd", bus.upd_valid, 0);
    // dt=10 -> 16>>2 = 4
    step(4'b0001, 1'b0); idle(9); step(4'b0, 1'b1);
    chk("ltp10_w0", wt(0), 68);
    chk("ltp10_mask", bus.ltp_mask, 4'b0001);
    chk("ltp10_upd", bus.upd_valid, 1);
    // dt=32 is outside the window
    idle(32); step(4'b0001, 1'b0); idle(31); step(4'b0, 1'b1);
    chk("dt32_w0", wt(0), 68);
    chk("dt32_upd", bus.upd_valid, 0);
    // dt=31: shift 7 gives delta 0
    idle(32); step(4'b0001, 1'b0); idle(30); step(4'b0, 1'b1);
    chk("dt31_w0", wt(0), 68);
    chk("dt31_upd", bus.upd_valid, 0);
    // dt=4: shift 1 gives +8
    idle(32); step(4'b0001, 1'b0); idle(3); step(4'b0, 1'b1);
    chk("dt4_w0", wt(0), 76);
    chk("dt4_mask", bus.ltp_mask, 4'b0001);
    // post e0, pre1 e5: dt=5 -> 12>>1 = 6
    idle(32); step(4'b0, 1'b1); idle(4); step(4'b0010, 1'b0);
    chk("ltd_w1", wt(1), LTD ? 58 : 64);
    chk("ltd_mask", bus.ltd_mask, LTD ? 4'b0010 : 4'b0000);
    chk("ltd_upd", bus.upd_valid, LTD ? 1 : 0);
    chk("ltd_ltp", bus.ltp_mask, 0);
    idle(32);
    load(2'd2, 8'd250);
    chk("load_w2", wt(2), 250);
    step(4'b0100, 1'b0); step(4'b0, 1'b1);
    chk("sat_w2", wt(2), 255);
    chk("sat_mask", bus.ltp_mask, 4'b0100);
    chk("sat_upd", bus.upd_valid, 1);
    idle(32);
    load(2'd2, 8'd100);
    step(4'b0100, 1'b0); step(4'b0, 1'b0); step(4'b0100, 1'b1);
    chk("simul_w2", wt(2), 100);
    chk("simul_upd", bus.upd_valid, 0);
    // write to synapse 0 wins over its LTP; synapse 1 still learns
    idle(32);
    load(2'd1, 8'd64);
    step(4'b0011, 1'b0);
    bus.wr_en = 1'b1; bus.wr_idx = 2'd0; bus.wr_data = 8'd10;
    step(4'b0, 1'b1);
    chk("prio_w0", wt(0), 10);
    chk("prio_w1", wt(1), 80);
    chk("prio_mask", bus.ltp_mask, 4'b0010);
    chk("prio_upd", bus.upd_valid, 1);
    idle(32);
    bus.learn_en = 1'b0;
    step(4'b0001, 1'b0); idle(2); step(4'b0, 1'b1);
    chk("nolearn_w0", wt(0), 10);
    chk("nolearn_upd", bus.upd_valid, 0);
    chk("nolearn_mask", bus.ltp_mask, 0);
    bus.learn_en = 1'b1;
    idle(32);
    step(4'b0001, 1'b0); idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_weight", bus.weight, 32'h40404040);
    chk("midrst_upd", bus.upd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0, 1'b1);
    chk("postrst_w0", wt(0), 64);
    chk("postrst_upd", bus.upd_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
